// File: rtl/alu_arbiter.sv
// ALU function codes shared with the requesters, the ALU datapath and the
// round-robin arbiter that lets NREQ requesters share a single ALU.

package common;
    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alufunc_t;
endpackage

// Combinational 64-bit ALU; unknown or ALU_NONE functions return 0.
module alu
    import common::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  alufunc_t    func_i,
    output logic [63:0] result_o
);

    // Decode the function; shifts use the low six bits of b.
    always_comb begin
        result_o = '0;
        case (func_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << b_i[5:0];
            ALU_SRL:  result_o = a_i >> b_i[5:0];
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[5:0]);
            ALU_SLT:  result_o = {63'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {63'd0, a_i < b_i};
            default:  result_o = '0;
        endcase
    end

endmodule

// Round-robin arbiter with one operation in flight. Operands are registered on
// grant; the ALU sits behind those registers, so the result is presented from
// the next cycle on and stays stable until the owning requester accepts it.
module alu_arbiter
    import common::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned SHAMT_W = 6
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NREQ-1:0]                      req_valid,
    output logic [NREQ-1:0]                      req_ready,
    input  logic [NREQ*64-1:0]                   req_a,
    input  logic [NREQ*64-1:0]                   req_b,
    input  logic [NREQ*$bits(alufunc_t)-1:0]     req_func,
    output logic [NREQ-1:0]                      resp_valid,
    input  logic [NREQ-1:0]                      resp_ready,
    output logic [63:0]                          resp_result,
    output logic                                 busy
);

    localparam int unsigned FuncW     = $bits(alufunc_t);
    localparam int unsigned PtrW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [63:0] ShamtMask = (64'd1 << SHAMT_W) - 64'd1;

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e           state_q, state_d;
    logic [PtrW-1:0]  owner_q, owner_d;
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [63:0]      a_q, a_d;
    logic [63:0]      b_q, b_d;
    alufunc_t         func_q, func_d;

    logic             slot_open;
    logic             grant_found;
    logic [PtrW-1:0]  grant_idx;
    logic [PtrW-1:0]  scan_idx;
    logic [NREQ-1:0]  grant;
    logic [63:0]      a_sel;
    logic [63:0]      b_sel;
    alufunc_t         func_sel;
    logic [63:0]      alu_result;

    // Pick the first valid requester at or above rr_ptr; a slot also opens when
    // the current result is being accepted, giving back-to-back issue.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        slot_open   = reset_n && ((state_q == StIdle) || resp_ready[owner_q]);
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = PtrW'((32'(rr_ptr_q) + k) % NREQ);
            if (slot_open && !grant_found && req_valid[scan_idx]) begin
                grant_found     = 1'b1;
                grant_idx       = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    // Mux the granted requester's operands; shifts keep only the shift amount.
    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        func_sel = ALU_NONE;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                a_sel    = req_a[64*k +: 64];
                b_sel    = req_b[64*k +: 64];
                func_sel = alufunc_t'(req_func[FuncW*k +: FuncW]);
            end
        end
        if (func_sel == ALU_SLL || func_sel == ALU_SRL || func_sel == ALU_SRA) begin
            b_sel = b_sel & ShamtMask;
        end
    end

    // Next state: a new accept wins over a plain response hand-off.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        func_d   = func_q;
        if (grant_found) begin
            state_d  = StResp;
            owner_d  = grant_idx;
            rr_ptr_d = PtrW'((32'(grant_idx) + 32'd1) % NREQ);
            a_d      = a_sel;
            b_d      = b_sel;
            func_d   = func_sel;
        end else if (state_q == StResp && resp_ready[owner_q]) begin
            state_d = StIdle;
        end
    end

    // State and operand registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= ALU_NONE;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            func_q   <= func_d;
        end
    end

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .func_i   (func_q),
        .result_o (alu_result)
    );

    // Outputs; cleared operand registers make the reset result 0.
    always_comb begin
        req_ready   = grant;
        busy        = (state_q == StResp);
        resp_valid  = busy ? (NREQ'(1) << owner_q) : '0;
        resp_result = alu_result;
    end

endmodule
